alu_rs: RTL and testbench



---
 rtl/alu_rs_pkg.sv | 67 ++++++
 rtl/alu_rs_select.sv | 26 ++
 rtl/alu_rs.sv | 151 +++++++++++++++
 tb/tb_alu_rs.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared CPU definitions for the ALU reservation station: op codes, tag/word types,
// slot layout and the common-data-bus operand capture helper.
package alu_rs_pkg;

   localparam int unsigned TAG_W = 3;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned OP_W  = 5;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 5'd0,
      OP_SUB  = 5'd1,
      OP_AND  = 5'd2,
      OP_OR   = 5'd3,
      OP_XOR  = 5'd4,
      OP_SLL  = 5'd5,
      OP_SRL  = 5'd6,
      OP_SRA  = 5'd7,
      OP_EQ   = 5'd8,
      OP_NE   = 5'd9,
      OP_LT   = 5'd10,
      OP_LTU  = 5'd11,
      OP_IDLE = 5'b11111
   } alu_op_e;

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [XLEN-1:0]  word_t;

   typedef struct packed {
      logic  r;
      word_t v;
   } operand_t;

   typedef struct packed {
      logic      busy;
      logic [OP_W-1:0] op;
      tag_t      des;
      logic      is_branch;
      operand_t  a;
      tag_t      q1;
      operand_t  b;
      tag_t      q2;
   } rs_slot_t;

   typedef struct packed {
      logic  valid;
      tag_t  tag;
      word_t value;
   } cdb_t;

   // cdb0 is checked first so it wins when both ports broadcast the same tag.
   function automatic operand_t capture(input operand_t cur, input tag_t q,
                                        input cdb_t c0, input cdb_t c1);
      operand_t res;
      res = cur;
      if (!cur.r) begin
         if (c0.valid && (c0.tag == q)) begin
            res.r = 1'b1;
            res.v = c0.value;
         end else if (c1.valid && (c1.tag == q)) begin
            res.r = 1'b1;
            res.v = c1.value;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-set-bit picker: one-hot, binary index and any-valid flag for a request vector.
module rs_select #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      for (int unsigned i = N; i > 0; i--) begin
         if (i_req[i-1]) begin
            o_onehot      = '0;
            o_onehot[i-1] = 1'b1;
            o_idx         = IW'(i - 1);
            o_any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: in-order-free slot allocation, dual-CDB wakeup with
// issue-time forwarding, and single lowest-index dispatch per cycle.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int unsigned ENTRIES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        issue_valid,
   input  logic [4:0]  issue_op,
   input  logic [2:0]  issue_des,
   input  logic        issue_is_branch,
   input  logic [31:0] issue_v1,
   input  logic [31:0] issue_v2,
   input  logic        issue_r1,
   input  logic        issue_r2,
   input  logic [2:0]  issue_q1,
   input  logic [2:0]  issue_q2,
   input  logic        cdb0_valid,
   input  logic [2:0]  cdb0_tag,
   input  logic [31:0] cdb0_value,
   input  logic        cdb1_valid,
   input  logic [2:0]  cdb1_tag,
   input  logic [31:0] cdb1_value,
   output logic        full,
   output logic [31:0] value_1,
   output logic [31:0] value_2,
   output logic [4:0]  op,
   output logic [2:0]  des,
   output logic        is_branch,
   output logic        pause
);

   localparam int unsigned IW = $clog2(ENTRIES);

   rs_slot_t r_slot [ENTRIES];
   rs_slot_t w_nxt  [ENTRIES];
   rs_slot_t w_new;

   logic [ENTRIES-1:0] w_busy;
   logic [ENTRIES-1:0] w_ready;
   logic [ENTRIES-1:0] w_rdy_oh;
   logic [ENTRIES-1:0] w_free_oh;
   logic [IW-1:0]      w_rdy_idx;
   logic [IW-1:0]      w_free_idx;
   logic               w_rdy_any;
   logic               w_free_any;
   logic               w_issue_ok;
   logic               w_unused_free_idx;
   cdb_t               w_cdb0;
   cdb_t               w_cdb1;

   assign w_cdb0 = '{valid: cdb0_valid, tag: cdb0_tag, value: cdb0_value};
   assign w_cdb1 = '{valid: cdb1_valid, tag: cdb1_tag, value: cdb1_value};

   always_comb begin
      w_busy  = '0;
      w_ready = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         w_busy[i]  = r_slot[i].busy;
         w_ready[i] = r_slot[i].busy & r_slot[i].a.r & r_slot[i].b.r;
      end
   end

   rs_select #(.N(ENTRIES)) u_sel_ready (
      .i_req    (w_ready),
      .o_onehot (w_rdy_oh),
      .o_idx    (w_rdy_idx),
      .o_any    (w_rdy_any)
   );

   rs_select #(.N(ENTRIES)) u_sel_free (
      .i_req    (~w_busy),
      .o_onehot (w_free_oh),
      .o_idx    (w_free_idx),
      .o_any    (w_free_any)
   );

   assign w_unused_free_idx = ^w_free_idx;

   // Full comes from registered busy bits only, so a same-cycle dispatch never unblocks issue.
   assign full       = ~w_free_any;
   assign w_issue_ok = issue_valid & w_free_any & ~flush;

   always_comb begin
      w_new           = '0;
      w_new.busy      = 1'b1;
      w_new.op        = issue_op;
      w_new.des       = issue_des;
      w_new.is_branch = issue_is_branch;
      w_new.a.r       = issue_r1;
      w_new.a.v       = issue_v1;
      w_new.q1        = issue_q1;
      w_new.b.r       = issue_r2;
      w_new.b.v       = issue_v2;
      w_new.q2        = issue_q2;
      w_new.a         = capture(w_new.a, issue_q1, w_cdb0, w_cdb1);
      w_new.b         = capture(w_new.b, issue_q2, w_cdb0, w_cdb1);
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         w_nxt[i] = r_slot[i];
         if (r_slot[i].busy) begin
            w_nxt[i].a = capture(r_slot[i].a, r_slot[i].q1, w_cdb0, w_cdb1);
            w_nxt[i].b = capture(r_slot[i].b, r_slot[i].q2, w_cdb0, w_cdb1);
         end
         if (w_rdy_oh[i]) begin
            w_nxt[i].busy = 1'b0;
         end
         if (w_issue_ok && w_free_oh[i]) begin
            w_nxt[i] = w_new;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_slot[i] <= '0;
         end
         value_1   <= '0;
         value_2   <= '0;
         op        <= OP_IDLE;
         des       <= '0;
         is_branch <= 1'b0;
         pause     <= 1'b1;
      end else if (flush) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_slot[i].busy <= 1'b0;
         end
         op    <= OP_IDLE;
         pause <= 1'b1;
      end else begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_slot[i] <= w_nxt[i];
         end
         if (w_rdy_any) begin
            value_1   <= r_slot[w_rdy_idx].a.v;
            value_2   <= r_slot[w_rdy_idx].b.v;
            op        <= r_slot[w_rdy_idx].op;
            des       <= r_slot[w_rdy_idx].des;
            is_branch <= r_slot[w_rdy_idx].is_branch;
            pause     <= 1'b0;
         end else begin
            op    <= OP_IDLE;
            pause <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Directed, table-driven bench for alu_rs: per-cycle vectors with hand-computed
// dispatch outputs, plus short hand sequences for latency and back-to-back dispatch.
module tb_alu_rs;

   localparam logic [4:0] ADD = 5'd0;
   localparam logic [4:0] SUB = 5'd1;
   localparam logic [4:0] AND = 5'd2;
   localparam logic [4:0] OR  = 5'd3;
   localparam logic [4:0] XOR = 5'd4;
   localparam logic [4:0] IDL = 5'b11111;

   typedef struct packed {
      logic v; logic [4:0] op; logic [2:0] des; logic br;
      logic [31:0] v1; logic r1; logic [2:0] q1;
      logic [31:0] v2; logic r2; logic [2:0] q2;
   } iss_t;

   typedef struct packed {
      logic v; logic [2:0] t; logic [31:0] d;
   } bus_t;

   typedef struct packed {
      logic full; logic pause; logic [4:0] op;
      logic [31:0] v1; logic [31:0] v2; logic [2:0] des; logic br;
   } exp_t;

   typedef struct packed {
      logic rst_n; logic fl; iss_t i; bus_t c0; bus_t c1; exp_t e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_op = '0;
   logic [2:0]  issue_des = '0;
   logic        issue_is_branch = 1'b0;
   logic [31:0] issue_v1 = '0;
   logic [31:0] issue_v2 = '0;
   logic        issue_r1 = 1'b0;
   logic        issue_r2 = 1'b0;
   logic [2:0]  issue_q1 = '0;
   logic [2:0]  issue_q2 = '0;
   logic        cdb0_valid = 1'b0;
   logic [2:0]  cdb0_tag = '0;
   logic [31:0] cdb0_value = '0;
   logic        cdb1_valid = 1'b0;
   logic [2:0]  cdb1_tag = '0;
   logic [31:0] cdb1_value = '0;
   logic        full;
   logic [31:0] value_1;
   logic [31:0] value_2;
   logic [4:0]  op;
   logic [2:0]  des;
   logic        is_branch;
   logic        pause;

   int errors = 0;
   int checks = 0;
   vec_t tbl[$];

   alu_rs #(.ENTRIES(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_des(issue_des),
      .issue_is_branch(issue_is_branch), .issue_v1(issue_v1), .issue_v2(issue_v2),
      .issue_r1(issue_r1), .issue_r2(issue_r2), .issue_q1(issue_q1), .issue_q2(issue_q2),
      .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_value(cdb0_value),
      .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
      .full(full), .value_1(value_1), .value_2(value_2), .op(op), .des(des),
      .is_branch(is_branch), .pause(pause)
   );

   always #5 clk = ~clk;

   function automatic iss_t I(logic [4:0] o, logic [2:0] d, logic b,
                              logic [31:0] a1, logic r1, logic [2:0] q1,
                              logic [31:0] a2, logic r2, logic [2:0] q2);
      return '{v: 1'b1, op: o, des: d, br: b, v1: a1, r1: r1, q1: q1, v2: a2, r2: r2, q2: q2};
   endfunction

   function automatic iss_t noi();
      return '0;
   endfunction

   function automatic bus_t C(logic [2:0] t, logic [31:0] d);
      return '{v: 1'b1, t: t, d: d};
   endfunction

   function automatic bus_t noc();
      return '0;
   endfunction

   function automatic exp_t E(logic f, logic p, logic [4:0] o, logic [31:0] a1,
                              logic [31:0] a2, logic [2:0] d, logic b);
      return '{full: f, pause: p, op: o, v1: a1, v2: a2, des: d, br: b};
   endfunction

   function automatic vec_t V(logic rn, logic fl, iss_t i, bus_t c0, bus_t c1, exp_t e);
      return '{rst_n: rn, fl: fl, i: i, c0: c0, c1: c1, e: e};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      rst             = x.rst_n;
      flush           = x.fl;
      issue_valid     = x.i.v;
      issue_op        = x.i.op;
      issue_des       = x.i.des;
      issue_is_branch = x.i.br;
      issue_v1        = x.i.v1;
      issue_r1        = x.i.r1;
      issue_q1        = x.i.q1;
      issue_v2        = x.i.v2;
      issue_r2        = x.i.r2;
      issue_q2        = x.i.q2;
      cdb0_valid      = x.c0.v;
      cdb0_tag        = x.c0.t;
      cdb0_value      = x.c0.d;
      cdb1_valid      = x.c1.v;
      cdb1_tag        = x.c1.t;
      cdb1_value      = x.c1.d;
   endtask

   task automatic chk_all(input string nm, input exp_t e);
      chk({nm, ".full"},  32'(full),      32'(e.full));
      chk({nm, ".pause"}, 32'(pause),     32'(e.pause));
      chk({nm, ".op"},    32'(op),        32'(e.op));
      chk({nm, ".v1"},    value_1,        e.v1);
      chk({nm, ".v2"},    value_2,        e.v2);
      chk({nm, ".des"},   32'(des),       32'(e.des));
      chk({nm, ".br"},    32'(is_branch), 32'(e.br));
   endtask

   initial begin : main
      int cnt;
      // reset
      tbl.push_back(V(0, 0, noi(), noc(), noc(), E(0, 1, IDL, 0, 0, 0, 0)));
      tbl.push_back(V(0, 0, noi(), noc(), noc(), E(0, 1, IDL, 0, 0, 0, 0)));
      // ADD both ready: dispatch two edges after presenting
      tbl.push_back(V(1, 0, I(ADD, 3, 0, 5, 1, 0, 7, 1, 0), noc(), noc(), E(0, 1, IDL, 0, 0, 0, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 0, ADD, 5, 7, 3, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 1, IDL, 5, 7, 3, 0)));
      // SUB waiting on tag 2, woken by cdb0
      tbl.push_back(V(1, 0, I(SUB, 4, 1, 32'hDEAD, 0, 2, 1, 1, 0), noc(), noc(), E(0, 1, IDL, 5, 7, 3, 0)));
      tbl.push_back(V(1, 0, noi(), C(2, 10), noc(), E(0, 1, IDL, 5, 7, 3, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 0, SUB, 10, 1, 4, 1)));
      // issue-time forwarding from cdb1
      tbl.push_back(V(1, 0, I(XOR, 5, 0, 32'hBAD, 0, 4, 3, 1, 0), noc(), C(4, 32'hFFFF_FFFF), E(0, 1, IDL, 10, 1, 4, 1)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 0, XOR, 32'hFFFF_FFFF, 3, 5, 0)));
      // same tag on both cdbs at issue: cdb0 wins
      tbl.push_back(V(1, 0, I(AND, 1, 0, 0, 0, 6, 0, 0, 6), C(6, 32'h11), C(6, 32'h22), E(0, 1, IDL, 32'hFFFF_FFFF, 3, 5, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 0, AND, 32'h11, 32'h11, 1, 0)));
      // fill four unready slots
      tbl.push_back(V(1, 0, I(OR, 0, 0, 0, 0, 1, 100, 1, 0), noc(), noc(), E(0, 1, IDL, 32'h11, 32'h11, 1, 0)));
      tbl.push_back(V(1, 0, I(ADD, 1, 0, 0, 0, 2, 200, 1, 0), noc(), noc(), E(0, 1, IDL, 32'h11, 32'h11, 1, 0)));
      tbl.push_back(V(1, 0, I(SUB, 2, 0, 50, 1, 0, 0, 0, 3), noc(), noc(), E(0, 1, IDL, 32'h11, 32'h11, 1, 0)));
      tbl.push_back(V(1, 0, I(ADD, 6, 0, 0, 0, 5, 7, 1, 0), noc(), noc(), E(1, 1, IDL, 32'h11, 32'h11, 1, 0)));
      // 5th issue dropped while full; slot 2 woken (cdb0 wins over cdb1)
      tbl.push_back(V(1, 0, I(ADD, 7, 0, 99, 1, 0, 99, 1, 0), C(3, 30), C(3, 31), E(1, 1, IDL, 32'h11, 32'h11, 1, 0)));
      tbl.push_back(V(1, 0, I(ADD, 7, 0, 99, 1, 0, 99, 1, 0), noc(), noc(), E(0, 0, SUB, 50, 30, 2, 0)));
      tbl.push_back(V(1, 0, I(ADD, 7, 0, 99, 1, 0, 99, 1, 0), noc(), noc(), E(1, 1, IDL, 50, 30, 2, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 0, ADD, 99, 99, 7, 0)));
      // slots 0 and 3 ready together: lowest index first
      tbl.push_back(V(1, 0, noi(), C(1, 1000), C(5, 5000), E(0, 1, IDL, 99, 99, 7, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 0, OR, 1000, 100, 0, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 0, ADD, 5000, 7, 6, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 1, IDL, 5000, 7, 6, 0)));
      // three busy, then flush with concurrent issue and cdb
      tbl.push_back(V(1, 0, I(ADD, 3, 0, 0, 0, 7, 1, 1, 0), noc(), noc(), E(0, 1, IDL, 5000, 7, 6, 0)));
      tbl.push_back(V(1, 0, I(SUB, 4, 0, 0, 0, 7, 1, 1, 0), noc(), noc(), E(0, 1, IDL, 5000, 7, 6, 0)));
      tbl.push_back(V(1, 1, I(ADD, 2, 0, 8, 1, 0, 9, 1, 0), C(2, 1), noc(), E(0, 1, IDL, 5000, 7, 6, 0)));
      tbl.push_back(V(1, 0, noi(), C(7, 77), noc(), E(0, 1, IDL, 5000, 7, 6, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 1, IDL, 5000, 7, 6, 0)));
      // reset overrides a pending ready slot and a same-cycle issue
      tbl.push_back(V(1, 0, I(ADD, 1, 0, 1, 1, 0, 2, 1, 0), noc(), noc(), E(0, 1, IDL, 5000, 7, 6, 0)));
      tbl.push_back(V(0, 0, I(ADD, 1, 0, 1, 1, 0, 2, 1, 0), C(7, 1), noc(), E(0, 1, IDL, 0, 0, 0, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 1, IDL, 0, 0, 0, 0)));
      tbl.push_back(V(1, 0, noi(), noc(), noc(), E(0, 1, IDL, 0, 0, 0, 0)));

      for (int k = 0; k < tbl.size(); k++) begin
         drive(tbl[k]);
         tick();
         chk_all($sformatf("vec%0d", k), tbl[k].e);
      end

      // latency: issue with both operands ready, bounded wait for dispatch
      drive(V(1, 0, I(5'd5, 2, 1, 32'hA, 1, 0, 32'hB, 1, 0), noc(), noc(), '0));
      tick();
      cnt = 1;
      drive(V(1, 0, noi(), noc(), noc(), '0));
      while (pause && cnt < 8) begin
         tick();
         cnt++;
      end
      chk("lat.edges", 32'(cnt), 32'd2);
      chk("lat.op", 32'(op), 32'd5);
      chk("lat.v1", value_1, 32'hA);
      chk("lat.br", 32'(is_branch), 32'd1);

      // issue B while A dispatches: both take effect, B follows next cycle
      drive(V(1, 0, I(ADD, 1, 0, 32'h100, 1, 0, 32'h1, 1, 0), noc(), noc(), '0));
      tick();
      drive(V(1, 0, I(SUB, 6, 0, 32'h200, 1, 0, 32'h2, 1, 0), noc(), noc(), '0));
      tick();
      chk("b2b.A.op", 32'(op), 32'(ADD));
      chk("b2b.A.v1", value_1, 32'h100);
      drive(V(1, 0, noi(), noc(), noc(), '0));
      tick();
      chk("b2b.B.pause", 32'(pause), 32'd0);
      chk("b2b.B.des", 32'(des), 32'd6);
      chk("b2b.B.v2", value_2, 32'h2);
      tick();
      chk("b2b.idle.op", 32'(op), 32'(IDL));
      chk("b2b.idle.full", 32'(full), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
